ddr3_fifo_arbiter: RTL
======================

DDR3_FIFO_ARBITER -- requirements
Module: ddr3_fifo_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 27, DDR3 address width; BRST_WIDTH, default 6, burst-count width; DATA_WIDTH, default 128, beat width; MASK_WIDTH, default 16, write-mask width.
REQ-002 SHALL have ports:
- clk_25MHz  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- calib_done  in  1  DDR3 init/calibration complete.
- m0_req_valid  in  1  requester 0 transaction request.
- m0_req_ready  out  1  grant pulse; request fields are latched.
- m0_req_we  in  1  1 = write, 0 = read.
- m0_req_addr  in  ADDR_WIDTH  start address.
- m0_req_len  in  BRST_WIDTH  beats minus 1.
- m0_wdata_valid  in  1  write beat valid.
- m0_wdata_ready  out  1  write beat accepted.
- m0_wdata  in  DATA_WIDTH  write beat.
- m0_wmask  in  MASK_WIDTH  write mask.
- m0_rdata_valid  out  1  read beat strobe.
- m0_rdata  out  DATA_WIDTH  read beat.
- m0_done  out  1  one-cycle transaction-complete pulse.
- m1_*  same set and meanings for requester 1.
- fifo_cmd_valid  out  1  bridge command valid.
- fifo_cmd_ready  in  1  bridge command ready.
- fifo_cmd_type  out  2  IDE=0, CMD=1, WT=2, RD=3.
- fifo_cmd_addr  out  ADDR_WIDTH  latched address.
- fifo_cmd_burst_cnt  out  BRST_WIDTH  latched len.
- fifo_cmd_wt_data  out  DATA_WIDTH  muxed write beat.
- fifo_cmd_wt_mask  out  MASK_WIDTH  muxed write mask.
- fifo_rsp_valid  out  1  read-beat request.
- fifo_rsp_ready  in  1  read beat available.
- fifo_rsp_data  in  DATA_WIDTH  read beat.
- busy  out  1  high in every state except ARB.

Function
REQ-003 SHALL implement FSM states ARB, IDE, WR_CMD, WR_DATA, RD_CMD, RD_DATA.
REQ-004 ARB: when calib_done=1 and at least one mN_req_valid=1, SHALL grant exactly one requester, pulse its mN_req_ready for 1 cycle, latch we/addr/len, and go to IDE.
REQ-005 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; after reset the priority pointer favours m0.
REQ-006 IDE: fifo_cmd_valid=1, type=IDE; on fifo_cmd_ready SHALL go to WR_CMD if we=1, else RD_CMD.
REQ-007 WR_CMD: type=CMD, with addr and burst_cnt=len; fifo_cmd_valid SHALL equal the granted mN_wdata_valid; wt_data/wt_mask SHALL combinationally mux the granted requester's beat.
REQ-008 A write beat handshake (valid && fifo_cmd_ready) SHALL assert the granted mN_wdata_ready in the same cycle and increment a beat counter.
REQ-009 After the WR_CMD beat: if len=0, SHALL go to ARB; otherwise go to WR_DATA (type=WT); after beat len+1 SHALL go to ARB.
REQ-010 RD_CMD: fifo_cmd_valid=1, type=RD; on fifo_cmd_ready SHALL go to RD_DATA.
REQ-011 RD_DATA: fifo_rsp_valid=1; each fifo_rsp_ready SHALL drive the granted mN_rdata_valid=1 in the same cycle with mN_rdata=fifo_rsp_data; after len+1 beats SHALL go to ARB. Requesters have no read backpressure.
REQ-012 mN_done SHALL pulse registered, in the cycle after the final write or read handshake.
REQ-013 Outside IDE, WR_*, RD_CMD: fifo_cmd_valid=0, type=IDE. Outside RD_DATA: fifo_rsp_valid=0. Non-granted requester strobes SHALL be 0.
REQ-014 Deassertion of calib_done or mN_req_valid mid-transaction SHALL NOT abort it; only new grants are blocked.
REQ-015 The beat counter SHALL be BRST_WIDTH+1 bits so that len=63 (64 beats) does not wrap.

Reset
REQ-016 While rstn=0: state=ARB; all valid/ready/done/busy outputs=0; fifo_cmd_type=IDE; latched addr, len and counter=0; RR pointer favours m0.
REQ-017 Reset asserted mid-transaction SHALL abandon it immediately with no done pulse.

Structure
REQ-018 Package ddr3_arb_pkg SHALL hold the FIFO type encodings, width defaults and the state enum.
REQ-019 The round-robin grant logic SHALL be one sub-module, ddr3_rr_arb2 (req[1:0] and advance in; one-hot grant out).

Verification
REQ-020 calib_done=0, m0 write request -> no m0_req_ready; after calib_done=1 -> grant within 1 cycle.
REQ-021 m0 write, addr 0, len 7, data 0x0123...3210 incrementing -> bridge sees IDE, CMD+beat0, then 7 WT beats with matching data/mask; m0_done once.
REQ-022 m1 read, len 7, fifo_rsp_ready toggled 50% -> exactly 8 m1_rdata_valid strobes carrying fifo_rsp_data; m1_done once.
REQ-023 m0 and m1 request simultaneously and continuously -> grants alternate m0, m1, m0, m1.
REQ-024 len=0 write and len=63 read -> 1 and 64 beats respectively; state returns to ARB.
REQ-025 rstn pulsed low during WR_DATA -> outputs at reset values; no done pulse; next grant goes to m0.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared definitions for the DDR3 FIFO arbiter: bridge command encodings,
// default bus widths and the transaction FSM state enum.
// Pure declarations; no logic, no latency, no flow control.

package ddr3_arb_pkg;

    localparam int DDR3_ADDR_WIDTH = 27;
    localparam int DDR3_BRST_WIDTH = 6;
    localparam int DDR3_DATA_WIDTH = 128;
    localparam int DDR3_MASK_WIDTH = 16;

    // Command type presented to the DDR3 FIFO bridge
    typedef enum logic [1:0] {
        FIFO_IDE = 2'd0,
        FIFO_CMD = 2'd1,
        FIFO_WT  = 2'd2,
        FIFO_RD  = 2'd3
    } fifo_cmd_t;

    typedef enum logic [2:0] {
        ST_ARB     = 3'd0,
        ST_IDE     = 3'd1,
        ST_WR_CMD  = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_RD_CMD  = 3'd4,
        ST_RD_DATA = 3'd5
    } arb_state_t;

endpackage

// File: rtl/ddr3_rr_arb2.sv
// Two-way round-robin grant: the requester not granted last wins a tie.
// Latency: grant is combinational from req; pointer updates on advance.
// Backpressure: none; caller asserts advance only when it consumes a grant.
//
// Ports:
//   clk_25MHz, rstn : clock, async active-low reset
//   req[1:0]        : request vector (bit N = requester N)
//   advance         : grant taken this cycle, move priority pointer
//   gnt[1:0]        : one-hot grant (all zero when no request)

module ddr3_rr_arb2 (
    input  logic       clk_25MHz,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 0 = requester 0 preferred on a tie, 1 = requester 1 preferred
    logic prio_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // After granting m0 the pointer favours m1 and vice versa, even when
    // the grant was uncontested.
    always_ff @(posedge clk_25MHz or negedge rstn) begin
        if (!rstn) begin
            prio_q <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            prio_q <= gnt[0];
        end
    end

endmodule

// File: rtl/ddr3_fifo_arbiter.sv
// Arbitrates two requesters onto one DDR3 FIFO bridge, one transaction at a time.
// Latency: grant combinational in ARB; beats pass through combinationally; done is registered (+1).
// Backpressure: write beats stall on wdata_valid/fifo_cmd_ready; read beats pace on fifo_rsp_ready.
//
// Ports:
//   clk_25MHz, rstn        : clock, async active-low reset
//   calib_done             : DDR3 ready; gates new grants only
//   mN_req_*               : transaction request (we/addr/len), ready = 1-cycle grant pulse
//   mN_wdata_*, mN_wmask   : write beats of granted requester
//   mN_rdata_valid/rdata   : read beats to granted requester (no backpressure)
//   mN_done                : one-cycle completion pulse
//   fifo_cmd_*             : command/write channel to bridge
//   fifo_rsp_*             : read channel from bridge
//   busy                   : transaction in flight (state != ARB)

module ddr3_fifo_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DDR3_ADDR_WIDTH,
    parameter int BRST_WIDTH = DDR3_BRST_WIDTH,
    parameter int DATA_WIDTH = DDR3_DATA_WIDTH,
    parameter int MASK_WIDTH = DDR3_MASK_WIDTH
) (
    input  logic                  clk_25MHz,
    input  logic                  rstn,
    input  logic                  calib_done,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [BRST_WIDTH-1:0] m0_req_len,
    input  logic                  m0_wdata_valid,
    output logic                  m0_wdata_ready,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [MASK_WIDTH-1:0] m0_wmask,
    output logic                  m0_rdata_valid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_done,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [BRST_WIDTH-1:0] m1_req_len,
    input  logic                  m1_wdata_valid,
    output logic                  m1_wdata_ready,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [MASK_WIDTH-1:0] m1_wmask,
    output logic                  m1_rdata_valid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_done,

    output logic                  fifo_cmd_valid,
    input  logic                  fifo_cmd_ready,
    output logic [1:0]            fifo_cmd_type,
    output logic [ADDR_WIDTH-1:0] fifo_cmd_addr,
    output logic [BRST_WIDTH-1:0] fifo_cmd_burst_cnt,
    output logic [DATA_WIDTH-1:0] fifo_cmd_wt_data,
    output logic [MASK_WIDTH-1:0] fifo_cmd_wt_mask,
    output logic                  fifo_rsp_valid,
    input  logic                  fifo_rsp_ready,
    input  logic [DATA_WIDTH-1:0] fifo_rsp_data,

    output logic                  busy
);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BRST_WIDTH-1:0] len;
    } req_t;

    arb_state_t            state_q, state_d;
    req_t                  req_q, req_d;
    logic                  sel_q, sel_d;      // granted requester index
    logic [BRST_WIDTH:0]   beat_q, beat_d;    // one extra bit: len=max means 2**BRST_WIDTH beats
    logic [1:0]            done_q, done_d;

    logic [1:0]            req_vec;
    logic [1:0]            gnt;
    logic                  advance;
    logic [1:0]            req_rdy;
    logic                  wdata_rdy;
    logic                  rdata_vld;
    logic                  cmd_valid;
    fifo_cmd_t             cmd_type;
    logic                  rsp_valid;
    logic                  wr_vld;
    logic                  last_beat;
    logic [1:0]            sel_onehot;

    // Including rstn keeps the combinational grant pulse low while reset is
    // held, even if calib_done and a request are already high.
    assign req_vec = {m1_req_valid, m0_req_valid} & {2{calib_done & rstn}};

    ddr3_rr_arb2 u_rr_arb (
        .clk_25MHz (clk_25MHz),
        .rstn      (rstn),
        .req       (req_vec),
        .advance   (advance),
        .gnt       (gnt)
    );

    assign wr_vld     = sel_q ? m1_wdata_valid : m0_wdata_valid;
    assign last_beat  = (beat_q == {1'b0, req_q.len});
    assign sel_onehot = sel_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        sel_d     = sel_q;
        beat_d    = beat_q;
        done_d    = 2'b00;
        advance   = 1'b0;
        req_rdy   = 2'b00;
        wdata_rdy = 1'b0;
        rdata_vld = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = FIFO_IDE;
        rsp_valid = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (gnt != 2'b00) begin
                    advance = 1'b1;
                    req_rdy = gnt;
                    sel_d   = gnt[1];
                    if (gnt[1]) begin
                        req_d.we   = m1_req_we;
                        req_d.addr = m1_req_addr;
                        req_d.len  = m1_req_len;
                    end else begin
                        req_d.we   = m0_req_we;
                        req_d.addr = m0_req_addr;
                        req_d.len  = m0_req_len;
                    end
                    beat_d  = '0;
                    state_d = ST_IDE;
                end
            end

            ST_IDE: begin
                cmd_valid = 1'b1;
                cmd_type  = FIFO_IDE;
                if (fifo_cmd_ready) begin
                    state_d = req_q.we ? ST_WR_CMD : ST_RD_CMD;
                end
            end

            // Beat 0 rides with the command; remaining beats go out as WT.
            ST_WR_CMD, ST_WR_DATA: begin
                cmd_valid = wr_vld;
                cmd_type  = (state_q == ST_WR_CMD) ? FIFO_CMD : FIFO_WT;
                if (wr_vld && fifo_cmd_ready) begin
                    wdata_rdy = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = ST_ARB;
                        done_d  = sel_onehot;
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end
            end

            ST_RD_CMD: begin
                cmd_valid = 1'b1;
                cmd_type  = FIFO_RD;
                if (fifo_cmd_ready) begin
                    state_d = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                rsp_valid = 1'b1;
                if (fifo_rsp_ready) begin
                    rdata_vld = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = ST_ARB;
                        done_d  = sel_onehot;
                    end
                end
            end

            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk_25MHz or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_ARB;
            req_q   <= '0;
            sel_q   <= 1'b0;
            beat_q  <= '0;
            done_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    assign m0_req_ready       = req_rdy[0];
    assign m1_req_ready       = req_rdy[1];
    assign m0_wdata_ready     = wdata_rdy & ~sel_q;
    assign m1_wdata_ready     = wdata_rdy &  sel_q;
    assign m0_rdata_valid     = rdata_vld & ~sel_q;
    assign m1_rdata_valid     = rdata_vld &  sel_q;
    assign m0_rdata           = fifo_rsp_data;
    assign m1_rdata           = fifo_rsp_data;
    assign m0_done            = done_q[0];
    assign m1_done            = done_q[1];

    assign fifo_cmd_valid     = cmd_valid;
    assign fifo_cmd_type      = cmd_type;
    assign fifo_cmd_addr      = req_q.addr;
    assign fifo_cmd_burst_cnt = req_q.len;
    assign fifo_cmd_wt_data   = sel_q ? m1_wdata : m0_wdata;
    assign fifo_cmd_wt_mask   = sel_q ? m1_wmask : m0_wmask;
    assign fifo_rsp_valid     = rsp_valid;

    assign busy               = (state_q != ST_ARB);

endmodule
